// File: rtl/fft4_sched_pkg.sv
// fft4_sched_pkg: shared types and constants for the radix-4 twiddle-stage
// group scheduler.
//   sched_state_e  : scheduler FSM states
//   PIPE_LAT       : multiply-stage latency (valid -> ready), cycles
//   MEM_LAT        : sample-memory read latency, cycles
//   groups_legal() : frame-size legality check used at start
package fft4_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } sched_state_e;

    localparam int unsigned PIPE_LAT = 6;
    localparam int unsigned MEM_LAT  = 1;

    function automatic logic groups_legal(input int unsigned n,
                                          input int unsigned max_groups);
        return (n >= 1) && (n <= max_groups);
    endfunction

endpackage

// File: rtl/fft4_credit_counter.sv
// fft4_credit_counter: saturating credit counter mirroring free space in the
// downstream output FIFO.
// Parameters: CREDITS - FIFO depth, also the reset value of the count.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   take       : consume one credit (caller only takes when has_credit)
//   give       : return one credit (ignored when already full)
//   has_credit : count is nonzero
//   count      : current credit count
module fft4_credit_counter #(
    parameter int unsigned CREDITS = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             take,
    input  logic                             give,
    output logic                             has_credit,
    output logic [$clog2(CREDITS+1)-1:0]     count
);

    localparam int unsigned CW = $clog2(CREDITS + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        // take and give together cancel out
        if (take && !give && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end else if (give && !take && (cnt_q != CW'(CREDITS))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CW'(CREDITS);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign has_credit = (cnt_q != '0);
    assign count      = cnt_q;

endmodule

// File: rtl/fft4_group_scheduler.sv
// fft4_group_scheduler: walks every butterfly group of one frame, issuing four
// sample-memory read addresses per group, then drives the twiddle-stage
// valid/lable one cycle later. Issue is throttled by downstream FIFO credits;
// stage ready returns are counted to detect end of frame.
// Optional feature: define FFT4_SCHED_INDEX_CHECK_EN to compare each returned
// dp_index against the expected return order (sticky seq_err); otherwise
// seq_err is tied low.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start, n_groups      : frame start pulse and group count (sampled in IDLE)
//   busy, done, cfg_err  : frame status / done pulse / illegal-size pulse
//   rd_en, rd_addr0..3   : sample-memory read strobe and x0..x3 addresses
//   dp_valid, dp_lable   : stage valid/label (read strobe delayed one cycle)
//   dp_ready, dp_index   : stage result present / its label
//   cred_ret             : downstream FIFO pop, returns one credit
//   seq_err              : sticky return-order error
module fft4_group_scheduler
    import fft4_sched_pkg::*;
#(
    parameter int unsigned LABEL_WIDTH = 11,
    parameter int unsigned ADDR_WIDTH  = 13,
    parameter int unsigned MAX_GROUPS  = 2048,
    parameter int unsigned CREDITS     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LABEL_WIDTH:0]   n_groups,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err,
    output logic                   rd_en,
    output logic [ADDR_WIDTH-1:0]  rd_addr0,
    output logic [ADDR_WIDTH-1:0]  rd_addr1,
    output logic [ADDR_WIDTH-1:0]  rd_addr2,
    output logic [ADDR_WIDTH-1:0]  rd_addr3,
    output logic                   dp_valid,
    output logic [LABEL_WIDTH-1:0] dp_lable,
    input  logic                   dp_ready,
    input  logic [LABEL_WIDTH-1:0] dp_index,
    input  logic                   cred_ret,
    output logic                   seq_err
);

    localparam int unsigned GW = LABEL_WIDTH + 1;

    sched_state_e state_q, state_d;

    logic [GW-1:0]         n_q, n_d;
    logic [GW-1:0]         g_q, g_d;
    logic [GW-1:0]         ret_q, ret_d;
    logic [ADDR_WIDTH-1:0] s1_q, s2_q, s3_q, s1_d, s2_d, s3_d;
    logic                  cfg_err_q;
    logic                  dp_valid_q;
    logic [LABEL_WIDTH-1:0] dp_lable_q;

    logic legal, accept, issue, last_issue, count_ret, has_credit;
    logic [$clog2(CREDITS+1)-1:0] unused_cred_count;

    assign legal      = groups_legal(32'(n_groups), MAX_GROUPS);
    assign accept     = (state_q == IDLE) && start && legal;
    assign issue      = (state_q == ISSUE) && has_credit;
    assign last_issue = issue && (g_q == n_q - GW'(1));
    assign count_ret  = dp_ready && ((state_q == ISSUE) || (state_q == DRAIN));

    fft4_credit_counter #(
        .CREDITS (CREDITS)
    ) u_credits (
        .clk        (clk),
        .rst        (rst),
        .take       (issue),
        .give       (cred_ret),
        .has_credit (has_credit),
        .count      (unused_cred_count)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)         state_d = ISSUE;
            ISSUE:   if (last_issue)     state_d = DRAIN;
            // Includes the return arriving this cycle so done follows the
            // last ready by exactly one cycle.
            DRAIN:   if (ret_d == n_q)   state_d = DONE;
            DONE:                        state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Address sums keep one spare bit; the frame-size limit 4N <= 2^ADDR_WIDTH
    // guarantees the carry is never set.
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [ADDR_WIDTH:0]   sum1, sum2, sum3;
    logic                  unused_carry;

    assign g_addr       = ADDR_WIDTH'(g_q);
    assign sum1         = {1'b0, g_addr} + {1'b0, s1_q};
    assign sum2         = {1'b0, g_addr} + {1'b0, s2_q};
    assign sum3         = {1'b0, g_addr} + {1'b0, s3_q};
    assign unused_carry = sum1[ADDR_WIDTH] ^ sum2[ADDR_WIDTH] ^ sum3[ADDR_WIDTH];

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        rd_en    = 1'b0;
        rd_addr0 = '0;
        rd_addr1 = '0;
        rd_addr2 = '0;
        rd_addr3 = '0;
        unique case (state_q)
            ISSUE:   begin busy = 1'b1; rd_en = issue; end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
        if (issue) begin
            rd_addr0 = g_addr;
            rd_addr1 = sum1[ADDR_WIDTH-1:0];
            rd_addr2 = sum2[ADDR_WIDTH-1:0];
            rd_addr3 = sum3[ADDR_WIDTH-1:0];
        end
    end

    // ---------------- frame datapath ----------------
    always_comb begin
        n_d   = n_q;
        s1_d  = s1_q;
        s2_d  = s2_q;
        s3_d  = s3_q;
        g_d   = g_q;
        ret_d = ret_q;
        if (accept) begin
            n_d   = n_groups;
            s1_d  = ADDR_WIDTH'(n_groups);
            s2_d  = ADDR_WIDTH'(n_groups) << 1;
            s3_d  = (ADDR_WIDTH'(n_groups) << 1) + ADDR_WIDTH'(n_groups);
            g_d   = '0;
            ret_d = '0;
        end else begin
            if (issue)     g_d   = g_q + GW'(1);
            if (count_ret) ret_d = ret_q + GW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q        <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            g_q        <= '0;
            ret_q      <= '0;
            cfg_err_q  <= 1'b0;
            dp_valid_q <= 1'b0;
            dp_lable_q <= '0;
        end else begin
            n_q        <= n_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            g_q        <= g_d;
            ret_q      <= ret_d;
            cfg_err_q  <= (state_q == IDLE) && start && !legal;
            dp_valid_q <= issue;
            dp_lable_q <= issue ? g_q[LABEL_WIDTH-1:0] : '0;
        end
    end

    assign cfg_err  = cfg_err_q;
    assign dp_valid = dp_valid_q;
    assign dp_lable = dp_lable_q;

`ifdef FFT4_SCHED_INDEX_CHECK_EN
    // Returns arrive in issue order, so the k-th ready must carry label k.
    logic seq_err_q, seq_err_d;

    always_comb begin
        seq_err_d = seq_err_q;
        if (accept) begin
            seq_err_d = 1'b0;
        end else if (count_ret && (dp_index != ret_q[LABEL_WIDTH-1:0])) begin
            seq_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_err_q <= 1'b0;
        end else begin
            seq_err_q <= seq_err_d;
        end
    end

    assign seq_err = seq_err_q;
`else
    logic unused_index;
    assign unused_index = ^dp_index;
    assign seq_err      = 1'b0;
`endif

endmodule

// File: doc/fft4_group_scheduler.md
# fft4_group_scheduler

Sequencer for the radix-4 twiddle-multiply stage. On a start pulse it walks every butterfly group of one frame and issues four sample-memory read addresses per group. One cycle later it drives the stage's `valid`/`lable` inputs. Issue is throttled by a credit count that mirrors the free space in the downstream output FIFO, because the multiply stage has a fixed latency and cannot stall. The block also counts the stage's `ready` returns to detect end of frame.

## Interface
Parameters:
- LABEL_WIDTH, 11: group label width; matches the stage `lable`/`index` ports.
- ADDR_WIDTH, 13: sample-memory address width.
- MAX_GROUPS, 2048: largest legal group count per frame.
- CREDITS, 8: downstream FIFO depth (credit counter reset value).

Ports:
- clk, in, 1: clock; single clock domain.
- rst, in, 1: reset; synchronous, active-high.
- start, in, 1: frame start pulse; sampled only in IDLE.
- n_groups, in, LABEL_WIDTH+1: groups in this frame, legal range 1..MAX_GROUPS; sampled with start.
- busy, out, 1: high from the cycle after an accepted start until the cycle done pulses.
- done, out, 1: one-cycle pulse when all groups have returned.
- cfg_err, out, 1: one-cycle pulse when start is seen with n_groups outside 1..MAX_GROUPS.
- rd_en, out, 1: sample-memory read strobe.
- rd_addr0..rd_addr3, out, ADDR_WIDTH each: read addresses for x0..x3.
- dp_valid, out, 1: stage `valid`.
- dp_lable, out, LABEL_WIDTH: stage `lable`.
- dp_ready, in, 1: stage `ready` (result present).
- dp_index, in, LABEL_WIDTH: stage `index`.
- cred_ret, in, 1: downstream FIFO pop; returns one credit.
- seq_err, out, 1: sticky label-order error; exists only with the index check compiled in.

## Operation
- States:
  - IDLE → ISSUE on start with legal n_groups.
  - ISSUE → DRAIN when the issue of group n_groups−1 completes.
  - DRAIN → DONE when the returned count equals n_groups.
  - DONE → IDLE unconditionally.
- Start handling:
  - On an accepted start, latch N=n_groups and stride registers S1=N, S2=2N, S3=3N; clear g, the returned counter and seq_err.
  - start outside IDLE is ignored (no error).
  - An illegal n_groups keeps the block in IDLE and pulses cfg_err.
- Issue in ISSUE, each cycle where credits>0:
  - rd_en=1, rd_addr0=g, rd_addr1=g+S1, rd_addr2=g+S2, rd_addr3=g+S3; then g increments.
  - Address sums are computed at ADDR_WIDTH+1 bits; 4·N ≤ 2^ADDR_WIDTH is a configuration requirement, with no wrap.
  - When credits=0, rd_en=0 and g holds.
- Credits:
  - Decrement on issue, increment on cred_ret; both in one cycle leaves the count unchanged.
  - cred_ret at CREDITS saturates (ignored).
  - Credits persist across frames and are reset only by rst.
- Return counting: each dp_ready increments the returned counter in ISSUE and DRAIN only. dp_ready in IDLE is ignored, covering stale results after a mid-frame reset.
- done asserts in the DONE state; busy is low in IDLE and DONE.

## Timing
- Reset value 0 for every output: busy, done, cfg_err, rd_en, all rd_addr, dp_valid, dp_lable, seq_err. Credits reset to CREDITS.
- The first rd_en occurs the cycle after the start edge.
- dp_valid/dp_lable equal rd_en and g registered one cycle, aligned with the memory's one-cycle read latency.
- Group issue at cycle t produces dp_ready at t+7 (1 memory + 6 stage).
- Peak throughput is one group per cycle when credits stay nonzero. Minimum frame time with no credit stall is N+8 cycles from start to done.
- rst asserted mid-frame returns to IDLE at the next edge: dp_valid drops, and no done is issued.

## Configuration
- FFT4_SCHED_INDEX_CHECK_EN defined:
  - Each dp_ready compares dp_index with the returned count (LABEL_WIDTH LSBs).
  - A mismatch sets seq_err, which holds until the next accepted start or rst.
- Undefined: seq_err is tied to 0 and the comparator is absent.

## Structure
- Package fft4_sched_pkg: state enum (IDLE, ISSUE, DRAIN, DONE), localparam PIPE_LAT=6, localparam MEM_LAT=1.
- Sub-module fft4_credit_counter: parameter CREDITS; inputs take/give; outputs has_credit and count; saturating.

## Test plan
- n_groups=4, CREDITS=8, cred_ret every cycle → rd_addr sets {0,4,8,12}, {1,5,9,13}, {2,6,10,14}, {3,7,11,15} on consecutive cycles; dp_lable 0..3; done exactly 12 cycles after the start edge.
- n_groups=16, CREDITS=8, no cred_ret → 8 issues then rd_en held at 0. A single cred_ret pulse → exactly one further issue.
- n_groups=0, then 2049 → cfg_err pulses each time, busy stays 0, rd_en stays 0.
- start re-pulsed while busy → ignored; the frame completes with its original N and done fires once.
- rst asserted 3 cycles into a 64-group frame → all outputs 0 next cycle. Stale dp_ready pulses are ignored. A following start with n_groups=2 completes normally.
- Index check compiled in, dp_index forced to 5 on the first return → seq_err=1 and held through done; cleared by the next start.
